// File: rtl/hv_cmd_framer.sv
// hv_cmd_framer: frames a 1..PAYLOAD_MAX byte payload as STX,payload,ETX,hex checksum,CR over valid/ready
// Optional stall abort is enabled by defining HV_CMD_TIMEOUT_EN.
module hv_cmd_framer #(
  parameter int         PAYLOAD_MAX    = 8,
  parameter logic [7:0] STX_BYTE       = 8'h02,
  parameter logic [7:0] ETX_BYTE       = 8'h03,
  parameter logic [7:0] TERM_BYTE      = 8'h0D,
  parameter logic [7:0] CHK_INIT       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                               Clk_In,
  input  logic                               Rst_N,
  input  logic                               Req_Valid,
  output logic                               Req_Ready,
  input  logic [$clog2(PAYLOAD_MAX+1)-1:0]   Req_Len,
  input  logic [8*PAYLOAD_MAX-1:0]           Req_Payload,
  output logic                               Out_Valid,
  input  logic                               Out_Ready,
  output logic [7:0]                         Out_Byte,
  output logic                               Busy,
  output logic                               Frame_Done,
  output logic                               Err_Len,
  output logic                               Err_Timeout
);
  localparam int LW = $clog2(PAYLOAD_MAX+1);
  localparam logic [LW-1:0] MAX_LEN = LW'(PAYLOAD_MAX);
  localparam logic [7:0] SEED = STX_BYTE + ETX_BYTE + CHK_INIT;
  typedef enum logic [2:0] {IDLE, SEND_STX, SEND_PAY, SEND_ETX, SEND_CHK_HI, SEND_CHK_LO, SEND_TERM} state_t;
  state_t state, state_nx;
  logic [8*PAYLOAD_MAX-1:0] sreg;
  logic [LW-1:0] cnt;
  logic [7:0] acc;
  logic done_q, err_len_q, abort, accept, hs, bad_len;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  assign accept     = Req_Valid && Req_Ready;
  assign hs         = Out_Valid && Out_Ready;
  assign bad_len    = Req_Len == '0 || Req_Len > MAX_LEN;
  assign Req_Ready  = state == IDLE;
  assign Busy       = state != IDLE;
  assign Out_Valid  = state != IDLE;
  assign Frame_Done = done_q;
  assign Err_Len    = err_len_q;
  always_comb
    Out_Byte = state == SEND_STX    ? STX_BYTE :
               state == SEND_PAY    ? sreg[8*PAYLOAD_MAX-1 -: 8] :
               state == SEND_ETX    ? ETX_BYTE :
               state == SEND_CHK_HI ? hex(acc[7:4]) :
               state == SEND_CHK_LO ? hex(acc[3:0]) :
               state == SEND_TERM   ? TERM_BYTE : 8'h00;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = accept && !bad_len ? SEND_STX : IDLE;
      SEND_STX:    state_nx = hs ? SEND_PAY : state;
      SEND_PAY:    state_nx = hs && cnt == LW'(1) ? SEND_ETX : state;
      SEND_ETX:    state_nx = hs ? SEND_CHK_HI : state;
      SEND_CHK_HI: state_nx = hs ? SEND_CHK_LO : state;
      SEND_CHK_LO: state_nx = hs ? SEND_TERM : state;
      SEND_TERM:   state_nx = hs ? IDLE : state;
      default:     state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge Clk_In or negedge Rst_N)
    if (!Rst_N) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      acc       <= '0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state     <= state_nx;
      done_q    <= hs && state == SEND_TERM;
      err_len_q <= accept && bad_len;
      if (accept) begin
        sreg <= Req_Payload;
        cnt  <= Req_Len;
        acc  <= SEED;
      end else if (hs && state == SEND_PAY) begin
        acc  <= acc + sreg[8*PAYLOAD_MAX-1 -: 8];
        sreg <= sreg << 8;
        cnt  <= cnt - 1'b1;
      end
    end
`ifdef HV_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT_CYCLES-1);
  logic [TW-1:0] stall;
  logic err_to_q;
  assign abort       = Out_Valid && !Out_Ready && stall == STALL_LAST;
  assign Err_Timeout = err_to_q;
  always_ff @(posedge Clk_In or negedge Rst_N)
    if (!Rst_N) begin
      stall    <= '0;
      err_to_q <= 1'b0;
    end else begin
      stall    <= Out_Valid && !Out_Ready && !abort ? stall + 1'b1 : '0;
      err_to_q <= abort;
    end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign Err_Timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_hv_cmd_framer.sv
// tb_hv_cmd_framer: table vectors, hand sequences and random frames checked against a frame-building model
module tb_hv_cmd_framer;
  logic        Clk_In = 1'b0, Rst_N = 1'b0, Req_Valid = 1'b0, Out_Ready = 1'b0;
  logic [3:0]  Req_Len = '0;
  logic [63:0] Req_Payload = '0;
  logic        Req_Ready, Out_Valid, Busy, Frame_Done, Err_Len, Err_Timeout;
  logic [7:0]  Out_Byte;
  int n_pass = 0, n_tot = 0, last_cycles = 0;
  logic [7:0] exp_q[$], got_q[$];
  typedef struct {
    int           len;
    logic [63:0]  pay;
    int           stall;
    int           n;
    logic [103:0] exp;
  } vec_t;
  vec_t vt[7];

  hv_cmd_framer #(.TIMEOUT_CYCLES(16)) dut (
    .Clk_In(Clk_In), .Rst_N(Rst_N), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Len(Req_Len), .Req_Payload(Req_Payload), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Byte(Out_Byte), .Busy(Busy), .Frame_Done(Frame_Done), .Err_Len(Err_Len),
    .Err_Timeout(Err_Timeout)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Frame is STX, payload, ETX, two hex chars of (STX+ETX+sum of payload) mod 256, CR
  task automatic model(input int len, input logic [63:0] pay);
    string hx = "0123456789ABCDEF";
    int sum = 2 + 3;
    exp_q = {};
    exp_q.push_back(8'h02);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay[63-8*i -: 8]);
      sum += int'(pay[63-8*i -: 8]);
    end
    sum = sum % 256;
    exp_q.push_back(8'h03);
    exp_q.push_back(hx[sum / 16]);
    exp_q.push_back(hx[sum % 16]);
    exp_q.push_back(8'h0D);
  endtask

  task automatic send_frame(input int len, input logic [63:0] pay, input int stall_pct, input bit hold_req);
    logic [7:0] held = '0;
    bit was_stall = 0;
    int viol = 0, early = 0, budget = 0;
    chk("req_ready_idle", Req_Ready, 1);
    Req_Valid = 1; Req_Len = 4'(len); Req_Payload = pay;
    tick();
    Req_Valid = 0;
    chk("stx_latency", {Out_Valid, Out_Byte}, {1'b1, 8'h02});
    chk("busy_in_frame", Busy, 1);
    got_q = {};
    while (got_q.size() < exp_q.size() && budget < 2000) begin
      Req_Valid = hold_req && got_q.size() < 3;
      Out_Ready = $urandom_range(99) >= stall_pct;
      if (was_stall && (!Out_Valid || Out_Byte !== held)) viol++;
      if (Frame_Done) early++;
      if (Out_Valid && Out_Ready) got_q.push_back(Out_Byte);
      was_stall = Out_Valid && !Out_Ready;
      held = Out_Byte;
      tick();
      budget++;
    end
    Out_Ready = 0; Req_Valid = 0;
    last_cycles = budget;
    chk("frame_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) chk($sformatf("frame_byte%0d", i), got_q[i], exp_q[i]);
      else chk("frame_byte", got_q[i], exp_q[i]);
    chk("stall_stable", viol, 0);
    chk("no_early_done", early, 0);
    chk("frame_done", Frame_Done, 1);
    chk("ready_after", Req_Ready, 1);
    chk("busy_after", Busy, 0);
  endtask

  task automatic bad_len(input int len);
    chk("bad_ready", Req_Ready, 1);
    Req_Valid = 1; Req_Len = 4'(len); Out_Ready = 1;
    tick();
    Req_Valid = 0;
    chk("err_len_pulse", Err_Len, 1);
    chk("err_len_no_out", Out_Valid, 0);
    chk("err_len_ready", Req_Ready, 1);
    tick();
    chk("err_len_once", Err_Len, 0);
    chk("err_len_still_idle", Out_Valid, 0);
    Out_Ready = 0;
  endtask

  initial begin
    int alive, errs;
    vt[0] = '{3, 64'h484F4EAAAAAAAAAA, 0,  8,  {64'h02484F4E0345410D, 40'h0}};
    vt[1] = '{3, 64'h484F465555555555, 40, 8,  {64'h02484F460345320D, 40'h0}};
    vt[2] = '{7, 64'h48535430303030FF, 0,  12, {96'h02485354303030300342340D, 8'h0}};
    vt[3] = '{8, 64'h0123456789ABCDEF, 20, 13, 104'h020123456789ABCDEF0343350D};
    vt[4] = '{0, 64'h484F4E0000000000, 0,  0,  104'h0};
    vt[5] = '{9, 64'h484F4E0000000000, 0,  0,  104'h0};
    vt[6] = '{15, 64'h484F4E0000000000, 0, 0,  104'h0};
    repeat (2) @(posedge Clk_In);
    #1;
    chk("rst_req_ready", Req_Ready, 1);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_out_byte", Out_Byte, 8'h00);
    chk("rst_busy", Busy, 0);
    chk("rst_frame_done", Frame_Done, 0);
    chk("rst_err_len", Err_Len, 0);
    chk("rst_err_timeout", Err_Timeout, 0);
    Rst_N = 1;
    tick();
    Out_Ready = 1;
    repeat (3) tick();
    chk("idle_ready_no_effect", {Out_Valid, Busy, Frame_Done}, 3'b000);
    Out_Ready = 0;
    for (int i = 0; i < 7; i++)
      if (vt[i].n == 0) bad_len(vt[i].len);
      else begin
        exp_q = {};
        for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].exp[103-8*j -: 8]);
        send_frame(vt[i].len, vt[i].pay, vt[i].stall, 1'b0);
        if (vt[i].stall == 0) chk("no_bubble", last_cycles, vt[i].n);
      end
    // mid-frame reset during payload
    Req_Valid = 1; Req_Len = 4'd3; Req_Payload = 64'h484F4E0000000000;
    tick();
    Req_Valid = 0; Out_Ready = 1;
    repeat (2) tick();
    chk("pre_reset_in_pay", Out_Byte, 8'h4F);
    #2 Rst_N = 0;
    #1;
    chk("mid_rst_outputs", {Out_Valid, Out_Byte, Req_Ready, Busy, Frame_Done, Err_Len, Err_Timeout},
        {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    Out_Ready = 0;
    tick();
    chk("mid_rst_no_done", Frame_Done, 0);
    Rst_N = 1;
    tick();
    model(3, 64'h484F4E0000000000);
    send_frame(3, 64'h484F4E0000000000, 0, 1'b0);
    // stall after STX
    alive = 0; errs = 0;
    Req_Valid = 1; Req_Len = 4'd3; Req_Payload = 64'h484F4E0000000000;
    tick();
    Req_Valid = 0; Out_Ready = 1;
    tick();
    Out_Ready = 0;
`ifdef HV_CMD_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      if (Out_Valid && !Err_Timeout && !Frame_Done) alive++;
      tick();
    end
    chk("to_stall_alive", alive, 16);
    chk("to_pulse", Err_Timeout, 1);
    chk("to_out_valid", Out_Valid, 0);
    chk("to_req_ready", Req_Ready, 1);
    chk("to_no_done", Frame_Done, 0);
    tick();
    chk("to_once", Err_Timeout, 0);
`else
    for (int k = 0; k < 40; k++) begin
      if (Err_Timeout) errs++;
      if (Out_Valid && Out_Byte == 8'h48) alive++;
      tick();
    end
    chk("stall_hold", alive, 40);
    chk("no_timeout", errs, 0);
    Rst_N = 0;
    tick();
    Rst_N = 1;
    tick();
`endif
    // random frames, some back-to-back, some with Req_Valid held while busy
    for (int r = 0; r < 25; r++) begin
      int len;
      logic [63:0] pay;
      len = $urandom_range(8, 1);
      pay = {$urandom, $urandom};
      model(len, pay);
      send_frame(len, pay, 30, r % 4 == 0);
      if (r % 3 == 0) tick();
    end
    repeat (3) tick();
    chk("final_idle", {Out_Valid, Busy}, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/hv_cmd_framer.md
Name: hv_cmd_framer

Overview:
- Parametrised successor to the fixed-length HV supply command builder.
- Frames an arbitrary-length ASCII payload (1..PAYLOAD_MAX bytes) as STX, payload, ETX, 2 ASCII-hex checksum chars, CR.
- The checksum is accumulated sequentially while the payload is being sent, not precomputed.
- Sits between the slow-control/command decoder and the HV UART transmitter, with valid/ready handshakes on both sides instead of a free-running pulse train.

Parameters:
- PAYLOAD_MAX, 8: maximum payload bytes; the request bus is 8*PAYLOAD_MAX bits wide.
- STX_BYTE, 8'h02: frame start byte.
- ETX_BYTE, 8'h03: payload end byte.
- TERM_BYTE, 8'h0D: frame terminator.
- CHK_INIT, 8'h00: constant added to the checksum seed.
- TIMEOUT_CYCLES, 1000000: stall limit. Used only when HV_CMD_TIMEOUT_EN is defined.

Ports:
- Clk_In  in  1  system clock.
- Rst_N  in  1  asynchronous active-low reset.
- Req_Valid  in  1  frame request valid.
- Req_Ready  out  1  framer can accept a request.
- Req_Len  in  $clog2(PAYLOAD_MAX+1)  payload length in bytes.
- Req_Payload  in  8*PAYLOAD_MAX  payload; byte 1 is in the top 8 bits, then following bytes downward.
- Out_Valid  out  1  Out_Byte valid to the UART.
- Out_Ready  in  1  UART accepts Out_Byte.
- Out_Byte  out  8  frame byte.
- Busy  out  1  a frame is in progress.
- Frame_Done  out  1  one-cycle pulse after the CR byte is accepted.
- Err_Len  out  1  one-cycle pulse: request rejected for bad length.
- Err_Timeout  out  1  one-cycle pulse: frame aborted on stall. Tied 0 without HV_CMD_TIMEOUT_EN.

Behaviour:
- Reset values:
  - Req_Ready=1.
  - Out_Valid=0, Out_Byte=8'h00.
  - Busy, Frame_Done, Err_Len, Err_Timeout = 0.
  - State=IDLE; payload shift register, byte counter and checksum accumulator cleared.
- Reset is asynchronous and can occur mid-frame. The frame is abandoned with no partial continuation, and Frame_Done is not pulsed.
- State machine: IDLE -> SEND_STX -> SEND_PAY -> SEND_ETX -> SEND_CHK_HI -> SEND_CHK_LO -> SEND_TERM -> IDLE.
- Request acceptance:
  - Req_Ready=1 only in IDLE.
  - A request is accepted on a cycle with Req_Valid & Req_Ready.
  - On accept: Req_Payload is captured into the shift register, the count is loaded with Req_Len, and the accumulator is seeded with STX_BYTE+ETX_BYTE+CHK_INIT (mod 256).
  - Busy=1 from the next cycle until the return to IDLE.
- Latency: acceptance at cycle T gives Out_Valid=1 with STX at T+1.
- Output handshake:
  - Each byte is held stable on Out_Byte with Out_Valid=1 until Out_Valid & Out_Ready.
  - On that handshake, the next byte is presented in the following cycle, with no bubble.
  - Out_Byte must not change while Out_Valid=1 and Out_Ready=0.
- SEND_PAY:
  - Presents the top byte of the shift register.
  - On handshake: adds that byte to the accumulator (mod 256), shifts left by 8, and decrements the count.
  - Leaves for SEND_ETX when the count reaches 0.
  - Bytes beyond Req_Len are never sent.
- Checksum characters:
  - SEND_CHK_HI sends the accumulator's upper nibble as uppercase ASCII hex: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46.
  - SEND_CHK_LO sends the lower nibble the same way.
- SEND_TERM sends TERM_BYTE. On its handshake: Frame_Done pulses, the FSM returns to IDLE, and Req_Ready=1 in the next cycle.
- Bad length: Req_Len=0 or Req_Len>PAYLOAD_MAX is accepted (one-cycle Req_Ready handshake), then:
  - Err_Len pulses at T+1.
  - No byte is emitted and the FSM stays in IDLE.
- Back-to-back requests: a new request can be accepted the cycle after Frame_Done. The minimum gap between one frame's CR handshake and the next frame's STX is 2 cycles.
- Simultaneous events:
  - Req_Valid held while Busy is ignored; the request is neither queued nor errored.
  - Out_Ready asserted while Out_Valid=0 has no effect.

Optional Feature:
- Macro HV_CMD_TIMEOUT_EN, when defined:
  - A stall counter increments each cycle with Out_Valid=1 and Out_Ready=0, and clears on every handshake.
  - When it reaches TIMEOUT_CYCLES-1, the frame aborts:
    - Out_Valid drops the next cycle and the FSM returns to IDLE.
    - Err_Timeout pulses once; Frame_Done does not.
- When not defined: there is no counter, the framer waits indefinitely, and Err_Timeout is constant 0.

Test Plan:
- HON frame: Req_Len=3, payload "HON" (48 4F 4E), Out_Ready=1 -> bytes 02 48 4F 4E 03 45 41 0D on consecutive cycles, STX at T+1, Frame_Done after 0D.
- HOF frame with random Out_Ready stalls: payload 48 4F 46 -> bytes 02 48 4F 46 03 45 32 0D. Out_Byte holds stable during every stall. No byte is lost or duplicated.
- 7-byte config: payload "HST0000" (48 53 54 30 30 30 30) -> bytes 02 48 53 54 30 30 30 30 03 42 34 0D (checksum B4).
- Length errors:
  - Req_Len=0 -> Err_Len pulse, no Out_Valid.
  - Req_Len=PAYLOAD_MAX+1 -> same.
  - Req_Len=PAYLOAD_MAX -> full frame of PAYLOAD_MAX+5 bytes.
- Mid-frame reset: Rst_N low during SEND_PAY -> all outputs at reset values immediately. A new HON request after release gives a clean frame.
- With HV_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: Out_Ready held 0 after STX -> Err_Timeout pulse after 16 stalled cycles, Out_Valid=0, Req_Ready=1, no Frame_Done.
